// File: rtl/ser_scheduler_pkg.sv
// Shared types and helpers for the serializer scheduler: FSM state encoding
// and the rule that maps a word's data_mod to its serialized bit count.
package ser_sched_pkg;

   localparam int WIDTH_DEFAULT = 16;
   localparam int W_IDX_DEFAULT = $clog2(WIDTH_DEFAULT);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } state_t;

   // mod 0 means a full word; mod 1 and 2 cannot be serialized and carry no bits.
   function automatic int unsigned valid_bits(input int unsigned mod, input int unsigned width);
      int unsigned bits;
      case (mod)
         32'd0:        bits = width;
         32'd1, 32'd2: bits = 32'd0;
         default:      bits = mod;
      endcase
      return bits;
   endfunction

endpackage

// File: rtl/ser_scheduler_if.sv
// Requester and serializer bus of the scheduler; the scheduler is the slave,
// whoever drives requests and models the serializer is the master.
interface ser_scheduler_if #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 16,
   parameter int W_IDX = $clog2(WIDTH),
   parameter int W_OWN = $clog2(N_REQ)
);
   logic [N_REQ*WIDTH-1:0] req_data_i;
   logic [N_REQ*W_IDX-1:0] req_mod_i;
   logic [N_REQ-1:0]       req_val_i;
   logic [N_REQ-1:0]       req_ready_o;
   logic [WIDTH-1:0]       ser_data_o;
   logic [W_IDX-1:0]       ser_mod_o;
   logic                   ser_val_o;
   logic                   ser_busy_i;
   logic [W_OWN-1:0]       owner_o;
   logic                   owner_val_o;
   logic                   done_o;
   logic                   drop_o;
   logic                   err_o;

   modport slave (
      input  req_data_i, req_mod_i, req_val_i, ser_busy_i,
      output req_ready_o, ser_data_o, ser_mod_o, ser_val_o,
             owner_o, owner_val_o, done_o, drop_o, err_o
   );

   modport master (
      output req_data_i, req_mod_i, req_val_i, ser_busy_i,
      input  req_ready_o, ser_data_o, ser_mod_o, ser_val_o,
             owner_o, owner_val_o, done_o, drop_o, err_o
   );
endinterface

// File: rtl/ser_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requesting index found
// when searching upward from last+1, wrapping at N_REQ-1.
module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int W_OWN = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [W_OWN-1:0] last,
   output logic [N_REQ-1:0] grant,
   output logic [W_OWN-1:0] grant_idx,
   output logic             grant_val
);

   // Scan offsets from farthest to nearest so the nearest requester after last wins.
   always_comb begin
      int idx_s;
      idx_s     = 0;
      grant_idx = '0;
      grant_val = 1'b0;
      for (int k = N_REQ; k >= 1; k--) begin
         idx_s     = (int'(last) + k) % N_REQ;
         grant_idx = req[idx_s] ? W_OWN'(idx_s) : grant_idx;
         grant_val = grant_val | req[idx_s];
      end
      grant = grant_val ? (N_REQ'(1) << grant_idx) : '0;
   end

endmodule

// File: rtl/ser_scheduler.sv
// Round-robin scheduler sharing one serializer between N_REQ requesters:
// accepts one word, issues it, tracks the busy window and reports completion.
module ser_scheduler
   import ser_sched_pkg::*;
#(
   parameter int N_REQ        = 4,
   parameter int WIDTH        = WIDTH_DEFAULT,
   parameter int W_IDX        = $clog2(WIDTH),
   parameter int BUSY_TIMEOUT = 4
) (
   input  logic           clk_i,
   input  logic           srst_i,
   ser_scheduler_if.slave bus
);

   localparam int W_OWN = $clog2(N_REQ);
   localparam int W_CNT = $clog2(BUSY_TIMEOUT + 1);
   localparam logic [W_CNT-1:0] CNT_LAST = W_CNT'(BUSY_TIMEOUT - 1);

   state_t             state_r;
   state_t             state_nxt_s;
   logic [W_CNT-1:0]   cnt_r;
   logic [W_CNT-1:0]   cnt_nxt_s;
   logic [W_OWN-1:0]   last_r;
   logic [W_OWN-1:0]   owner_r;
   logic [WIDTH-1:0]   data_r;
   logic [W_IDX-1:0]   mod_r;
   logic               ser_val_r;
   logic               owner_val_r;
   logic               done_r;
   logic               drop_r;
   logic               err_r;

   logic [N_REQ-1:0]   grant_s;
   logic [W_OWN-1:0]   grant_idx_s;
   logic               grant_val_s;
   logic [N_REQ-1:0]   ready_s;
   logic [WIDTH-1:0]   grant_data_s;
   logic [W_IDX-1:0]   grant_mod_s;
   logic               zero_len_s;
   logic               accept_s;
   logic               timeout_s;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .W_OWN (W_OWN)
   ) u_arb (
      .req       (bus.req_val_i),
      .last      (last_r),
      .grant     (grant_s),
      .grant_idx (grant_idx_s),
      .grant_val (grant_val_s)
   );

   assign grant_data_s = bus.req_data_i[int'(grant_idx_s)*WIDTH +: WIDTH];
   assign grant_mod_s  = bus.req_mod_i[int'(grant_idx_s)*W_IDX +: W_IDX];
   assign zero_len_s   = (valid_bits(32'(grant_mod_s), 32'(WIDTH)) == 32'd0);
   assign accept_s     = (state_r == IDLE) && grant_val_s;

   // Ready is only offered in IDLE so at most one word is ever outstanding.
   always_comb begin
      if ((state_r == IDLE) && srst_i) begin
         ready_s = grant_s;
      end else begin
         ready_s = '0;
      end
   end

   // Next-state and busy-timeout counter.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      timeout_s   = 1'b0;
      case (state_r)
         IDLE: begin
            cnt_nxt_s = '0;
            if (grant_val_s && !zero_len_s) begin
               state_nxt_s = ISSUE;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ISSUE: begin
            cnt_nxt_s   = '0;
            state_nxt_s = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (bus.ser_busy_i) begin
               state_nxt_s = WAIT_DONE;
            end else if (cnt_r == CNT_LAST) begin
               state_nxt_s = IDLE;
               timeout_s   = 1'b1;
            end else begin
               cnt_nxt_s = cnt_r + W_CNT'(1);
            end
         end
         WAIT_DONE: begin
            if (!bus.ser_busy_i) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = WAIT_DONE;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State, capture registers and registered status outputs.
   always_ff @(posedge clk_i) begin
      if (!srst_i) begin
         state_r     <= IDLE;
         cnt_r       <= '0;
         last_r      <= W_OWN'(N_REQ - 1);
         owner_r     <= '0;
         data_r      <= '0;
         mod_r       <= '0;
         ser_val_r   <= 1'b0;
         owner_val_r <= 1'b0;
         done_r      <= 1'b0;
         drop_r      <= 1'b0;
         err_r       <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         cnt_r       <= cnt_nxt_s;
         ser_val_r   <= (state_nxt_s == ISSUE);
         owner_val_r <= (state_nxt_s != IDLE);
         done_r      <= (state_r == WAIT_DONE) && !bus.ser_busy_i;
         drop_r      <= accept_s && zero_len_s;
         err_r       <= err_r | timeout_s;
         if (accept_s) begin
            last_r <= grant_idx_s;
         end
         if (accept_s && !zero_len_s) begin
            owner_r <= grant_idx_s;
            data_r  <= grant_data_s;
            mod_r   <= grant_mod_s;
         end
      end
   end

   assign bus.req_ready_o = ready_s;
   assign bus.ser_data_o  = data_r;
   assign bus.ser_mod_o   = mod_r;
   assign bus.ser_val_o   = ser_val_r;
   assign bus.owner_o     = owner_r;
   assign bus.owner_val_o = owner_val_r;
   assign bus.done_o      = done_r;
   assign bus.drop_o      = drop_r;
   assign bus.err_o       = err_r;

endmodule

// File: tb/tb_ser_scheduler.sv
// Bench for ser_scheduler: directed scenarios plus random traffic, with a
// serializer stub and a transaction-level reference model checked every cycle.
module tb_ser_scheduler;

   localparam int N  = 4;
   localparam int W  = 16;
   localparam int WI = 4;
   localparam int TO = 4;

   logic clk  = 1'b0;
   logic srst = 1'b0;
   always #5 clk = ~clk;

   ser_scheduler_if #(.N_REQ(N), .WIDTH(W), .W_IDX(WI)) bus ();

   ser_scheduler #(
      .N_REQ(N), .WIDTH(W), .W_IDX(WI), .BUSY_TIMEOUT(TO)
   ) dut (
      .clk_i  (clk),
      .srst_i (srst),
      .bus    (bus.slave)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int bits_of(input int m);
      if (m == 0) return W;
      if (m == 1 || m == 2) return 0;
      return m;
   endfunction

   function automatic int rr_pick(input logic [N-1:0] v, input int last);
      for (int k = 1; k <= N; k++) begin
         if (v[(last + k) % N]) return (last + k) % N;
      end
      return -1;
   endfunction

   // Serializer stub: optional start delay, then busy for one cycle per bit.
   logic stub_en = 1'b1;
   int   stub_dly_max = 0;
   int   st_dly = 0;
   int   st_cnt = 0;
   always @(posedge clk) begin
      if (!srst) begin
         st_dly <= 0;
         st_cnt <= 0;
      end else if (bus.ser_val_o && stub_en) begin
         st_dly <= int'($urandom_range(32'(stub_dly_max), 0));
         st_cnt <= bits_of(int'(bus.ser_mod_o));
      end else if (st_dly > 0) begin
         st_dly <= st_dly - 1;
      end else if (st_cnt > 0) begin
         st_cnt <= st_cnt - 1;
      end
   end
   assign bus.ser_busy_i = (st_cnt != 0) && (st_dly == 0);

   logic [W-1:0]  wdata [N];
   logic [WI-1:0] wmod  [N];
   logic [N-1:0]  wval;
   logic [N-1:0]  acc_mask = '0;
   int            mode = 0;

   int            cyc = 0;
   int            m_last = N - 1;
   bit            m_out = 1'b0;
   bit            m_seen = 1'b0;
   int            m_wait = 0;
   bit            m_err = 1'b0;
   int            m_issue = -1;
   int            m_done = -1;
   int            m_drop = -1;
   logic [W-1:0]  m_word = '0;
   logic [WI-1:0] m_mod = '0;
   int            m_owner = 0;
   int            gv;
   logic [N-1:0]  exp_ready;

   int            n_done_obs = 0;
   int            n_drop_obs = 0;
   int            n_sv_obs = 0;
   int            obs_grants[$];
   logic [W-1:0]  obs_data = '0;
   int            obs_done_owner = -1;

   // Reference model: predicts every output from the scheduling rules each cycle.
   always @(negedge clk) begin
      cyc++;
      acc_mask = '0;
      n_done_obs += int'(bus.done_o);
      n_drop_obs += int'(bus.drop_o);
      n_sv_obs   += int'(bus.ser_val_o);
      if (!srst) begin
         m_last = N - 1; m_out = 1'b0; m_seen = 1'b0; m_wait = 0; m_err = 1'b0;
         m_issue = -1; m_done = -1; m_drop = -1;
      end else begin
         gv = rr_pick(bus.req_val_i, m_last);
         exp_ready = '0;
         if (!m_out && gv >= 0) exp_ready[gv] = 1'b1;
         check_eq("ctrl", {bus.req_ready_o, bus.ser_val_o, bus.owner_val_o, bus.done_o, bus.drop_o, bus.err_o},
                  {exp_ready, (cyc == m_issue), m_out, (cyc == m_done), (cyc == m_drop), m_err});
         if (cyc == m_issue) begin
            check_eq("ser_data", bus.ser_data_o, m_word);
            check_eq("ser_mod", bus.ser_mod_o, m_mod);
            check_eq("issue_owner", bus.owner_o, m_owner);
         end
         if (cyc == m_done) check_eq("done_owner", bus.owner_o, m_owner);
         if (bus.ser_val_o) obs_data = bus.ser_data_o;
         if (bus.done_o) obs_done_owner = int'(bus.owner_o);
         for (int i = 0; i < N; i++) begin
            if (bus.req_ready_o[i] && bus.req_val_i[i]) obs_grants.push_back(i);
         end
         if (m_out) begin
            if (cyc != m_issue) begin
               if (!m_seen) begin
                  m_wait++;
                  if (bus.ser_busy_i) m_seen = 1'b1;
                  else if (m_wait == TO) begin m_err = 1'b1; m_out = 1'b0; end
               end else if (!bus.ser_busy_i) begin
                  m_done = cyc + 1;
                  m_out  = 1'b0;
               end
            end
         end else if (gv >= 0) begin
            acc_mask[gv] = 1'b1;
            m_last = gv;
            if (bits_of(int'(bus.req_mod_i[gv*WI +: WI])) == 0) begin
               m_drop = cyc + 1;
            end else begin
               m_out = 1'b1; m_seen = 1'b0; m_wait = 0; m_issue = cyc + 1;
               m_word = bus.req_data_i[gv*W +: W];
               m_mod = bus.req_mod_i[gv*WI +: WI];
               m_owner = gv;
            end
         end
      end
   end

   task automatic apply();
      for (int i = 0; i < N; i++) begin
         bus.req_data_i[i*W +: W]  = wdata[i];
         bus.req_mod_i[i*WI +: WI] = wmod[i];
      end
      bus.req_val_i = wval;
   endtask

   task automatic new_word(input int i);
      wdata[i] = W'($urandom);
      wmod[i]  = WI'($urandom_range(15, 0));
   endtask

   task automatic step();
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
         if (acc_mask[i]) begin
            if (mode == 0) wval[i] = 1'b0;
            else if (mode == 1) wdata[i] = wdata[i] + 16'h0101;
            else begin wval[i] = ($urandom_range(1, 0) == 1); new_word(i); end
         end else if (mode == 2) begin
            if (!wval[i] && $urandom_range(3, 0) == 0) begin wval[i] = 1'b1; new_word(i); end
            else if (wval[i] && $urandom_range(31, 0) == 0) wval[i] = 1'b0;
         end
      end
      apply();
   endtask

   int d0, g0, s0;
   int exp_rr [5] = '{0, 1, 2, 3, 0};

   initial begin
      for (int i = 0; i < N; i++) begin
         wdata[i] = 16'h1111 * W'(i + 1);
         wmod[i]  = 4'd5;
      end
      wval = 4'b1111;
      mode = 1;
      apply();

      // Reset with all requesters pending: nothing granted, all outputs zero.
      step(); step();
      @(negedge clk); #1;
      check_eq("rst_outs", {bus.req_ready_o, bus.ser_val_o, bus.owner_val_o, bus.done_o, bus.drop_o,
                            bus.err_o, bus.owner_o, bus.ser_data_o, bus.ser_mod_o}, 64'd0);

      // Round-robin with all four holding valid.
      step(); srst = 1'b1;
      @(negedge clk); #1;
      check_eq("first_grant", bus.req_ready_o, 4'b0001);
      for (int k = 0; k < 300 && obs_grants.size() < 5; k++) step();
      check_eq("rr_count", 64'(obs_grants.size() >= 5), 64'd1);
      if (obs_grants.size() >= 5) begin
         for (int i = 0; i < 5; i++) check_eq($sformatf("rr_order%0d", i), 64'(obs_grants[i]), 64'(exp_rr[i]));
      end
      wval = '0; apply();
      for (int k = 0; k < 30; k++) step();

      // Single full-width word from requester 2.
      mode = 0;
      wdata[2] = 16'hA5A5; wmod[2] = 4'd0; wval = 4'b0100; apply();
      d0 = n_done_obs; g0 = obs_grants.size();
      for (int k = 0; k < 60 && n_done_obs == d0; k++) step();
      check_eq("single_done", 64'(n_done_obs), 64'(d0 + 1));
      check_eq("single_grant", 64'(obs_grants.size() > g0 ? obs_grants[g0] : -1), 64'd2);
      check_eq("single_data", obs_data, 16'hA5A5);
      check_eq("single_owner", 64'(obs_done_owner), 64'd2);
      step(); step();

      // Zero-length words are dropped without touching the serializer.
      d0 = n_drop_obs; s0 = n_sv_obs;
      wdata[1] = 16'hFFFF; wmod[1] = 4'd1; wval = 4'b0010; apply();
      for (int k = 0; k < 20 && n_drop_obs == d0; k++) step();
      wmod[1] = 4'd2; wval = 4'b0010; apply();
      for (int k = 0; k < 20 && n_drop_obs < d0 + 2; k++) step();
      step(); step();
      check_eq("zl_drops", 64'(n_drop_obs - d0), 64'd2);
      check_eq("zl_no_issue", 64'(n_sv_obs - s0), 64'd0);

      // Busy never rises: sticky error, back to IDLE, still accepting.
      stub_en = 1'b0; d0 = n_done_obs;
      wdata[0] = 16'h1234; wmod[0] = 4'd0; wval = 4'b0001; apply();
      for (int k = 0; k < 30 && !bus.err_o; k++) step();
      check_eq("timeout_err", bus.err_o, 1'b1);
      check_eq("timeout_nodone", 64'(n_done_obs), 64'(d0));
      stub_en = 1'b1;
      wdata[3] = 16'hBEEF; wmod[3] = 4'd7; wval = 4'b1000; apply();
      for (int k = 0; k < 40 && n_done_obs == d0; k++) step();
      check_eq("after_timeout_done", 64'(n_done_obs), 64'(d0 + 1));
      check_eq("err_sticky", bus.err_o, 1'b1);

      // Reset while serializing: no done, and arbitration restarts at 0.
      wdata[2] = 16'hC3C3; wmod[2] = 4'd0; wval = 4'b0100; apply();
      for (int k = 0; k < 20 && !bus.ser_busy_i; k++) step();
      step(); step(); step();
      srst = 1'b0; d0 = n_done_obs;
      wmod[0] = 4'd3; wval = 4'b1001; apply();
      step();
      @(negedge clk); #1;
      check_eq("rst_owner_val", bus.owner_val_o, 1'b0);
      check_eq("rst_err", bus.err_o, 1'b0);
      step(); srst = 1'b1;
      @(negedge clk); #1;
      check_eq("rst_regrant", bus.req_ready_o, 4'b0001);
      for (int k = 0; k < 40; k++) step();
      check_eq("rst_nodone", 64'(n_done_obs), 64'(d0 + 2));

      // Random traffic with variable serializer start delay.
      mode = 2; stub_dly_max = 2; d0 = n_done_obs;
      for (int k = 0; k < 3000; k++) step();
      mode = 0; wval = '0; apply();
      for (int k = 0; k < 40; k++) step();
      check_eq("rand_done", 64'((n_done_obs - d0) > 20), 64'd1);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
